reg_hazard_scoreboard: RTL and testbench

Issue-side counterpart of the general register file in the five-stage pipeline. The register file answers reads and accepts write-back. This block tracks every in-flight destination register between issue (D) and write-back (W). For each source operand read in D, it decides whether to stall, forward from E or M, or read the register file (W-stage results reach D through the file's internal bypass). It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/reg_hazard_scoreboard.sv | 62 ++++++
 tb/tb_reg_hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard: tracks in-flight destinations E/M/W and resolves stall/forwarding for D-stage operands
module reg_hazard_scoreboard #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  input  logic [1:0]             issue_tnew,
  input  logic [4:0]             rs,
  input  logic [4:0]             rt,
  input  logic [1:0]             rs_tuse,
  input  logic [1:0]             rt_tuse,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             fwd_rs,
  output logic [1:0]             fwd_rt,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] tnew;
  } slot_t;
  slot_t sl [3];
  logic req_rs, req_rt;
  logic [1:0] f_rs, f_rt;
  function automatic logic [2:0] resolve(input logic [4:0] s, input logic [1:0] t);
    logic found;
    logic [1:0] hit;
    found = 1'b0;
    hit = 2'd0;
    for (int i = 2; i >= 0; i--)
      if (sl[i].valid && sl[i].rd == s && s != 5'd0) begin
        found = 1'b1;
        hit = 2'(i);
      end
    return !found || hit == 2'd2 ? 3'd0 :
           {t != 2'd3 && sl[hit].tnew > t, sl[hit].tnew == 2'd0 ? hit + 2'd1 : 2'd0};
  endfunction
  function automatic slot_t age(input slot_t s);
    return {s.valid, s.rd, s.tnew == 2'd0 ? 2'd0 : s.tnew - 2'd1};
  endfunction
  always_comb begin
    {req_rs, f_rs} = resolve(rs, rs_tuse);
    {req_rt, f_rt} = resolve(rt, rt_tuse);
    stall = issue_valid && (req_rs || req_rt);
    fwd_rs = stall ? 2'd0 : f_rs;
    fwd_rt = stall ? 2'd0 : f_rt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sl <= '{default: '0};
      stall_cnt <= '0;
    end else begin
      sl[0] <= issue_valid && !stall && !flush && issue_rd != 5'd0 ? {1'b1, issue_rd, issue_tnew} : '0;
      sl[1] <= age(sl[0]);
      sl[2] <= age(sl[1]);
      stall_cnt <= stall && !(&stall_cnt) ? stall_cnt + STALL_CNT_W'(1) : stall_cnt;
    end
  end
endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// tb_reg_hazard_scoreboard: scoreboard bench with an age-based reference model of in-flight writers
module tb_reg_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset, issue_valid, flush;
  logic [4:0] issue_rd, rs, rt;
  logic [1:0] issue_tnew, rs_tuse, rt_tuse;
  logic stall, stall2;
  logic [1:0] fwd_rs, fwd_rt, fwd_rs2, fwd_rt2;
  logic [15:0] stall_cnt;
  logic [1:0] stall_cnt2;

  always #5 clk = ~clk;

  reg_hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_tnew(issue_tnew), .rs(rs), .rt(rt), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
    .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
  );

  reg_hazard_scoreboard #(.STALL_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_tnew(issue_tnew), .rs(rs), .rt(rt), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
    .flush(flush), .stall(stall2), .fwd_rs(fwd_rs2), .fwd_rt(fwd_rt2), .stall_cnt(stall_cnt2)
  );

  typedef struct {
    int rd;
    int tnew;
    int age;
  } flight_t;

  typedef struct {
    logic        st;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  flight_t fl[$];
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  bit push_en = 0;
  bit cur_stall = 0;
  int c16m = 0;
  int c2m = 0;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic void src(input int s, input int t, output bit req, output int fwd);
    int best;
    int rem;
    best = -1;
    req = 0;
    fwd = 0;
    foreach (fl[i])
      if (s != 0 && fl[i].rd == s && (best < 0 || fl[i].age < fl[best].age)) best = i;
    if (best >= 0 && fl[best].age < 2) begin
      rem = fl[best].tnew - fl[best].age;
      if (rem < 0) rem = 0;
      req = (t != 3) && (rem > t);
      if (rem == 0) fwd = fl[best].age + 1;
    end
  endfunction

  task automatic drive(input bit r, input bit v, input int rd, input int tn,
                       input int s1, input int t1, input int s2, input int t2, input bit f);
    bit q1, q2;
    int f1, f2;
    exp_t e;
    reset = r;
    issue_valid = v;
    issue_rd = 5'(rd);
    issue_tnew = 2'(tn);
    rs = 5'(s1);
    rs_tuse = 2'(t1);
    rt = 5'(s2);
    rt_tuse = 2'(t2);
    flush = f;
    src(s1, t1, q1, f1);
    src(s2, t2, q2, f2);
    cur_stall = v && (q1 || q2);
    e.st = cur_stall;
    e.frs = cur_stall ? 2'd0 : 2'(f1);
    e.frt = cur_stall ? 2'd0 : 2'(f2);
    e.c16 = 16'(c16m);
    e.c2 = 2'(c2m);
    if (push_en) q.push_back(e);
  endtask

  task automatic tick();
    flight_t n[$];
    @(posedge clk);
    if (reset) begin
      fl.delete();
      c16m = 0;
      c2m = 0;
    end else begin
      foreach (fl[i]) if (fl[i].age < 2) n.push_back('{fl[i].rd, fl[i].tnew, fl[i].age + 1});
      if (issue_valid && !cur_stall && !flush && issue_rd != 0)
        n.push_back('{int'(issue_rd), int'(issue_tnew), 0});
      fl = n;
      if (cur_stall) begin
        if (c16m < 65535) c16m++;
        if (c2m < 3) c2m++;
      end
    end
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 3, 0, 3, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", 16'(stall), 16'(e.st));
      chk("fwd_rs", 16'(fwd_rs), 16'(e.frs));
      chk("fwd_rt", 16'(fwd_rt), 16'(e.frt));
      chk("stall_cnt", stall_cnt, e.c16);
      chk("stall_w2", 16'(stall2), 16'(e.st));
      chk("fwd_rs_w2", 16'(fwd_rs2), 16'(e.frs));
      chk("fwd_rt_w2", 16'(fwd_rt2), 16'(e.frt));
      chk("stall_cnt_w2", 16'(stall_cnt2), 16'(e.c2));
    end
  end

  initial begin
    repeat (2) begin
      drive(1, 1, $urandom_range(0, 31), $urandom_range(0, 2), $urandom_range(0, 31),
            $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 1));
      tick();
    end
    push_en = 1;
    idle(); #1;
    chk("rst_stall", 16'(stall), 0);
    chk("rst_fwd_rs", 16'(fwd_rs), 0);
    chk("rst_fwd_rt", 16'(fwd_rt), 0);
    chk("rst_cnt", stall_cnt, 0);
    tick();
    drive(0, 1, 5, 2, 0, 3, 0, 3, 0); tick();
    repeat (3) begin
      drive(0, 1, 0, 0, 5, 0, 0, 3, 0); tick();
    end
    drive(0, 1, 6, 1, 0, 3, 0, 3, 0); tick();
    drive(0, 1, 0, 0, 6, 0, 0, 3, 0); #1;
    chk("lu_stall", 16'(stall), 1);
    tick();
    drive(0, 1, 0, 0, 6, 0, 0, 3, 0); #1;
    chk("lu_nostall", 16'(stall), 0);
    chk("lu_fwd_m", 16'(fwd_rs), 2);
    tick();
    drive(0, 1, 8, 1, 0, 3, 0, 3, 0); tick();
    drive(0, 1, 0, 0, 0, 3, 8, 1, 0); #1;
    chk("alu_nostall", 16'(stall), 0);
    tick();
    drive(0, 1, 0, 0, 0, 3, 8, 1, 0); #1;
    chk("alu_fwd_m", 16'(fwd_rt), 2);
    tick();
    drive(0, 1, 3, 0, 0, 3, 0, 3, 0); tick();
    drive(0, 1, 3, 0, 0, 3, 0, 3, 0); tick();
    drive(0, 1, 0, 0, 3, 0, 0, 3, 0); #1;
    chk("youngest_e", 16'(fwd_rs), 1);
    tick();
    drive(0, 1, 0, 2, 0, 3, 0, 3, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 3, 0); #1;
    chk("r0_stall", 16'(stall), 0);
    chk("r0_fwd", 16'(fwd_rs), 0);
    tick();
    drive(0, 1, 5, 2, 0, 3, 0, 3, 0); tick();
    drive(0, 0, 0, 0, 5, 0, 5, 0, 0); #1;
    chk("bubble_stall", 16'(stall), 0);
    tick();
    idle(); tick();
    idle(); tick();
    drive(0, 1, 9, 2, 0, 3, 0, 3, 1); tick();
    drive(0, 1, 0, 0, 9, 0, 0, 3, 0); #1;
    chk("flush_stall", 16'(stall), 0);
    tick();
    drive(1, 0, 0, 0, 0, 3, 0, 3, 0); tick();
    repeat (3) begin
      drive(0, 1, 5, 2, 0, 3, 0, 3, 0); tick();
      repeat (2) begin
        drive(0, 1, 0, 0, 5, 0, 0, 3, 0); tick();
      end
    end
    idle(); #1;
    chk("sat_w2", 16'(stall_cnt2), 3);
    chk("cnt_w16", stall_cnt, 6);
    tick();
    drive(0, 1, 5, 2, 0, 3, 0, 3, 0); tick();
    drive(1, 1, 0, 0, 5, 0, 0, 3, 0); tick();
    idle(); #1;
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall_cnt_w2", 16'(stall_cnt2), 0);
    chk("rst_no_stall", 16'(stall), 0);
    tick();
    repeat (600) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      tick();
    end
    idle(); tick();
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
